// File: rtl/word_serializer_if.sv
// Handshake and serial-output bundle for word_serializer.
// The slave modport is the serializer; the master modport is the upstream/downstream environment.
interface word_serializer_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             ct;
    logic             out;
    logic             busy;
    logic [7:0]       frames;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output ct,
        output out,
        output busy,
        output frames
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  ct,
        input  out,
        input  busy,
        input  frames
    );
endinterface

// File: rtl/word_serializer.sv
// Parallel-to-serial word converter: LSB first with ct framing, then an idle gap.
// Define WORD_SERIALIZER_PARITY_EN to append one even-parity bit after each word.
module word_serializer #(
    parameter int WIDTH = 8,
    parameter int GAP   = 1
) (
    input  logic                clk,
    input  logic                rst,
    word_serializer_if.slave    bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
`ifdef WORD_SERIALIZER_PARITY_EN
    localparam logic [1:0] S_PAR   = 2'd2;
`endif
    localparam logic [1:0] S_GAP   = 2'd3;

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [3:0]    LAST_GAP = 4'(GAP - 1);

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] shreg_q,  shreg_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [3:0]       gap_q,    gap_d;
    logic [7:0]       frames_q, frames_d;
    logic             ct_q,     ct_d;
    logic             out_q,    out_d;
`ifdef WORD_SERIALIZER_PARITY_EN
    logic             par_q,    par_d;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        frames_d = frames_q;
        ct_d     = 1'b0;
        out_d    = 1'b0;
`ifdef WORD_SERIALIZER_PARITY_EN
        par_d    = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                // in_ready is high only here, so in_valid alone completes the handshake.
                if (bus.in_valid) begin
                    state_d = S_SHIFT;
                    shreg_d = bus.in_data >> 1;
                    cnt_d   = '0;
                    ct_d    = 1'b1;
                    out_d   = bus.in_data[0];
`ifdef WORD_SERIALIZER_PARITY_EN
                    par_d   = ^bus.in_data;
`endif
                end
            end
            S_SHIFT: begin
                if (cnt_q == LAST_BIT) begin
`ifdef WORD_SERIALIZER_PARITY_EN
                    state_d  = S_PAR;
                    ct_d     = 1'b1;
                    out_d    = par_q;
`else
                    state_d  = S_GAP;
                    gap_d    = '0;
                    frames_d = frames_q + 8'd1;
`endif
                end else begin
                    ct_d    = 1'b1;
                    out_d   = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                    cnt_d   = cnt_q + CW'(1);
                end
            end
`ifdef WORD_SERIALIZER_PARITY_EN
            S_PAR: begin
                state_d  = S_GAP;
                gap_d    = '0;
                frames_d = frames_q + 8'd1;
            end
`endif
            S_GAP: begin
                if (gap_q == LAST_GAP) state_d = S_IDLE;
                else                   gap_d   = gap_q + 4'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            gap_q    <= '0;
            frames_q <= '0;
            ct_q     <= 1'b0;
            out_q    <= 1'b0;
`ifdef WORD_SERIALIZER_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
            frames_q <= frames_d;
            ct_q     <= ct_d;
            out_q    <= out_d;
`ifdef WORD_SERIALIZER_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    assign bus.in_ready = (state_q == S_IDLE);
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.ct       = ct_q;
    assign bus.out      = out_q;
    assign bus.frames   = frames_q;
endmodule

// File: tb/tb_word_serializer.sv
// Self-checking bench for word_serializer: a queue of expected (ct,out) slots per accepted word
// serves as the reference model; directed scenarios plus randomized traffic.
module tb_word_serializer;
    localparam int W = 8;
    localparam int G = 1;
`ifdef WORD_SERIALIZER_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int PERIOD = 1 + W + G + PB;

    typedef struct packed {
        logic ct;
        logic bit_v;
        logic first_gap;
    } slot_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    word_serializer_if #(.WIDTH(W)) bus ();
    word_serializer #(.WIDTH(W), .GAP(G)) dut (.clk(clk), .rst(rst), .bus(bus));

    slot_t      exp_q[$];
    logic       exp_ct, exp_out, exp_ready;
    logic [7:0] exp_frames;
    int         cyc, last_hs;
    bit         period_chk;
    int         n_checks, n_bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_outputs();
        check("ct",       32'(bus.ct),       32'(exp_ct));
        check("out",      32'(bus.out),      32'(exp_out));
        check("in_ready", 32'(bus.in_ready), 32'(exp_ready));
        check("busy",     32'(bus.busy),     32'(!exp_ready));
        check("frames",   32'(bus.frames),   32'(exp_frames));
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_ct     = 1'b0;
        exp_out    = 1'b0;
        exp_ready  = 1'b1;
        exp_frames = 8'd0;
        last_hs    = -1;
    endtask

    // Called at a falling edge: compare, drive, advance the model across one rising edge.
    task automatic cycle(input logic v, input logic [W-1:0] d);
        slot_t s;
        compare_outputs();
        bus.in_valid = v;
        bus.in_data  = d;
        if (v && exp_ready) begin
            if (period_chk && last_hs >= 0) check("accept_period", 32'(cyc - last_hs), 32'(PERIOD));
            last_hs = cyc;
            for (int i = 0; i < W; i++) exp_q.push_back('{1'b1, d[i], 1'b0});
            if (PB == 1) exp_q.push_back('{1'b1, ^d, 1'b0});
            for (int i = 0; i < G; i++) exp_q.push_back('{1'b0, 1'b0, (i == 0)});
        end
        @(posedge clk);
        cyc++;
        if (exp_q.size() > 0) begin
            s          = exp_q.pop_front();
            exp_ct     = s.ct;
            exp_out    = s.bit_v;
            exp_ready  = 1'b0;
            if (s.first_gap) exp_frames = exp_frames + 8'd1;
        end else begin
            exp_ct    = 1'b0;
            exp_out   = 1'b0;
            exp_ready = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic abort_reset();
        compare_outputs();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("abort_ct",     32'(bus.ct),       32'd0);
        check("abort_out",    32'(bus.out),      32'd0);
        check("abort_frames", 32'(bus.frames),   32'd0);
        check("abort_busy",   32'(bus.busy),     32'd0);
        check("abort_ready",  32'(bus.in_ready), 32'd1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] seq;
        n_checks = 0;
        n_bad    = 0;
        cyc      = 0;
        period_chk = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        rst = 1'b1;
        model_reset();

        // Reset held, then released with no traffic.
        repeat (3) @(negedge clk);
        compare_outputs();
        rst = 1'b0;
        repeat (5) cycle(1'b0, '0);

        // Single word 0xA5, observed LSB first.
        cycle(1'b1, 8'hA5);
        for (int i = 0; i < 8; i++) begin
            seq[i] = bus.out;
            cycle(1'b0, 8'h00);
        end
        check("a5_bits", 32'(seq), 32'h0000_00A5);
        repeat (PERIOD) cycle(1'b0, 8'h00);
        check("a5_frames", 32'(bus.frames), 32'd1);

        // Back-pressure: valid held with changing data.
        period_chk = 1'b1;
        last_hs    = -1;
        for (int i = 0; i < 4 * PERIOD; i++) cycle(1'b1, 8'($urandom));
        period_chk = 1'b0;
        repeat (PERIOD) cycle(1'b0, 8'h00);

`ifdef WORD_SERIALIZER_PARITY_EN
        cycle(1'b1, 8'h07);
        repeat (8) cycle(1'b0, 8'h00);
        check("par07_ct",  32'(bus.ct),  32'd1);
        check("par07_bit", 32'(bus.out), 32'd1);
        repeat (PERIOD) cycle(1'b0, 8'h00);
        cycle(1'b1, 8'h03);
        repeat (8) cycle(1'b0, 8'h00);
        check("par03_ct",  32'(bus.ct),  32'd1);
        check("par03_bit", 32'(bus.out), 32'd0);
        repeat (PERIOD) cycle(1'b0, 8'h00);
`endif

        // Mid-frame reset during bit 3 of 0xFF, then a full word.
        cycle(1'b1, 8'hFF);
        repeat (3) cycle(1'b0, 8'h00);
        check("bit3_ct", 32'(bus.ct), 32'd1);
        abort_reset();
        repeat (2) cycle(1'b0, 8'h00);
        cycle(1'b1, 8'h3C);
        repeat (PERIOD + 2) cycle(1'b0, 8'h00);
        check("post_abort_frames", 32'(bus.frames), 32'd1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++)
            cycle(($urandom_range(0, 2) != 0), 8'($urandom));
        repeat (PERIOD) cycle(1'b0, 8'h00);

        // Counter wrap across 256 back-to-back frames.
        abort_reset();
        period_chk = 1'b1;
        for (int k = 0; k < 256 * PERIOD; k++) begin
            if (k == 255 * PERIOD) check("frames_255", 32'(bus.frames), 32'd255);
            cycle(1'b1, 8'($urandom));
        end
        check("frames_wrap", 32'(bus.frames), 32'd0);
        period_chk = 1'b0;
        repeat (PERIOD + 1) cycle(1'b0, 8'h00);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule
